// File: rtl/wf_led_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wf_led_sequencer                                              |
// | Brief    : multi-channel LED driver (OFF/ON/BLINK/PWM per channel) with  |
// |            shared tick prescaler and PWM counter. Optional perceptual    |
// |            dimming curve via macro WF_LED_SEQ_GAMMA_EN.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module wf_led_sequencer #(
    parameter int CLK_HZ      = 16000000,
    parameter int TICK_HZ     = 1000,
    parameter int CHANNELS    = 4,
    parameter int PERIOD_BITS = 16,
    parameter int PWM_BITS    = 8,
    parameter int RESET_BLINK = 500
) (
    input  logic                                                 WF_CLK,
    input  logic                                                 WF_RST,
    input  logic                                                 cfg_valid,
    output logic                                                 cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]   cfg_chan,
    input  logic [1:0]                                           cfg_mode,
    input  logic [PERIOD_BITS-1:0]                               cfg_period,
    input  logic [PWM_BITS-1:0]                                  cfg_duty,
    output logic                                                 cfg_err,
    output logic                                                 tick_out,
    output logic [CHANNELS-1:0]                                  WF_LED
);
    localparam int c_DIV   = CLK_HZ / TICK_HZ;
    localparam int c_PRE_W = $clog2(c_DIV);
    localparam int c_CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(c_DIV - 1);
    localparam logic [c_CW:0]      c_NCHAN   = (c_CW + 1)'(CHANNELS);

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_ON    = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;
    localparam logic [1:0] c_MODE_PWM   = 2'b11;

    logic [c_PRE_W-1:0]     r_pre;
    logic [PWM_BITS-1:0]    r_pwm;
    logic                   r_ready;
    logic                   r_err;
    logic [CHANNELS-1:0]    r_led;
    logic [1:0]             r_mode   [CHANNELS];
    logic [PERIOD_BITS-1:0] r_period [CHANNELS];
    logic [PWM_BITS-1:0]    r_duty   [CHANNELS];
    logic [PERIOD_BITS-1:0] r_phase  [CHANNELS];
    logic [CHANNELS-1:0]    r_bstate;

    logic                   w_tick;
    logic                   w_accept;
    logic                   w_chan_ok;
    logic                   w_wr;
    logic [PERIOD_BITS-1:0] w_last   [CHANNELS];
    logic [CHANNELS-1:0]    w_raw;

    assign w_tick    = (r_pre == c_PRE_MAX);
    assign w_accept  = cfg_valid & r_ready;
    assign w_chan_ok = ({1'b0, cfg_chan} < c_NCHAN);
    assign w_wr      = w_accept & w_chan_ok;

    // Shared time base, handshake readiness and sticky error
    always_ff @(posedge WF_CLK) begin
        if (WF_RST) begin
            r_pre   <= '0;
            r_pwm   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + c_PRE_W'(1);
            r_pwm   <= r_pwm + PWM_BITS'(1);
            r_ready <= 1'b1;
            if (w_accept && !w_chan_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [PWM_BITS-1:0] w_eff_duty;
`ifdef WF_LED_SEQ_GAMMA_EN
        logic [2*PWM_BITS-1:0] w_sq;
        assign w_sq       = {{PWM_BITS{1'b0}}, r_duty[g]} * {{PWM_BITS{1'b0}}, r_duty[g]};
        assign w_eff_duty = PWM_BITS'(w_sq >> PWM_BITS);
`else
        assign w_eff_duty = r_duty[g];
`endif
        // A zero half-period behaves as one tick
        assign w_last[g] = (r_period[g] == '0) ? '0 : r_period[g] - PERIOD_BITS'(1);
        assign w_raw[g]  = (r_mode[g] == c_MODE_ON)
                         | ((r_mode[g] == c_MODE_BLINK) & r_bstate[g])
                         | ((r_mode[g] == c_MODE_PWM) & (r_pwm < w_eff_duty));
    end

    // Per-channel configuration and blink phase; a write beats a coincident tick
    always_ff @(posedge WF_CLK) begin
        if (WF_RST) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_mode[i]   <= c_MODE_OFF;
                r_period[i] <= '0;
                r_duty[i]   <= '0;
                r_phase[i]  <= '0;
                r_bstate[i] <= 1'b0;
            end
            r_led <= '0;
            if (RESET_BLINK != 0) begin
                r_mode[0]   <= c_MODE_BLINK;
                r_period[0] <= PERIOD_BITS'(RESET_BLINK);
                r_bstate[0] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wr && (cfg_chan == c_CW'(i))) begin
                    r_mode[i]   <= cfg_mode;
                    r_period[i] <= cfg_period;
                    r_duty[i]   <= cfg_duty;
                    r_phase[i]  <= '0;
                    r_bstate[i] <= 1'b1;
                end else if (w_tick && (r_mode[i] == c_MODE_BLINK)) begin
                    if (r_phase[i] == w_last[i]) begin
                        r_phase[i]  <= '0;
                        r_bstate[i] <= ~r_bstate[i];
                    end else begin
                        r_phase[i] <= r_phase[i] + PERIOD_BITS'(1);
                    end
                end
            end
            r_led <= w_raw;
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick_out  = w_tick;
    assign WF_LED    = r_led;

endmodule
`default_nettype wire
